// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU pipeline: widths, the bubble word and
// the fetch-stage state encoding.
package cpu_pkg;
  localparam int          CPU_PC_W = 16;
  localparam logic [15:0] CPU_NOP  = 16'h0000;
  localparam logic [3:0]  OP_HLT   = 4'hF;

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN, HALTED} if_state_t;

  function automatic logic is_hlt(input logic [15:0] w);
    return w[15:12] == OP_HLT;
  endfunction
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Priority: flush > hold > load; with none of them
// asserted the register drains to a bubble so each word is presented once.
module if_id_reg import cpu_pkg::*; #(
  parameter int          PC_W      = CPU_PC_W,
  parameter logic [15:0] NOP_INSTR = CPU_NOP
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            hold,
  input  logic            load,
  input  logic [15:0]     d_instr,
  input  logic [PC_W-1:0] d_pc_plus1,
  output logic [15:0]     instr,
  output logic [PC_W-1:0] pc_plus1,
  output logic            valid
);
  logic [15:0]     instr_q, instr_d;
  logic [PC_W-1:0] pc1_q, pc1_d;
  logic            valid_q, valid_d;

  always_comb begin
    instr_d = instr_q;
    pc1_d   = pc1_q;
    valid_d = valid_q;
    if (flush) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (!hold) begin
      if (load) begin
        instr_d = d_instr;
        pc1_d   = d_pc_plus1;
        valid_d = 1'b1;
      end else begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP_INSTR;
      pc1_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc1_q   <= pc1_d;
      valid_q <= valid_d;
    end
  end

  assign instr    = instr_q;
  assign pc_plus1 = pc1_q;
  assign valid    = valid_q;
endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, runs the variable-latency imem
// handshake, and feeds the IF/ID register with stall, redirect and halt handling.
module if_stage import cpu_pkg::*; #(
  parameter int              PC_W      = CPU_PC_W,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [15:0]     NOP_INSTR = CPU_NOP
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  output logic            imem_rd,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_rdy,
  input  logic [15:0]     imem_data,
  output logic [15:0]     instr,
  output logic [PC_W-1:0] pc_plus1,
  output logic            valid,
  output logic            halted
);
  if_state_t       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] drain_addr_q, drain_addr_d;
  logic [15:0]     skid_q, skid_d;
  logic            flush, load;
  logic [15:0]     load_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
      skid_q       <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      skid_q       <= skid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    skid_d       = skid_q;
    case (state_q)
      FETCH: begin
        if (branch_taken) begin
          // Redirect wins over any response (including a HLT) this cycle.
          pc_d = branch_target;
          if (!imem_rdy) begin
            state_d      = DRAIN;
            drain_addr_d = pc_q;
          end
        end else if (imem_rdy) begin
          if (stall) begin
            state_d = HOLD;
            skid_d  = imem_data;
          end else begin
            pc_d = pc_q + 1'b1;
            if (is_hlt(imem_data)) state_d = HALTED;
          end
        end
      end
      HOLD: begin
        if (branch_taken) begin
          pc_d    = branch_target;
          state_d = FETCH;
        end else if (!stall) begin
          pc_d    = pc_q + 1'b1;
          state_d = is_hlt(skid_q) ? HALTED : FETCH;
        end
      end
      DRAIN: begin
        // Old request stays on the bus until it completes; its data is dropped.
        if (branch_taken) pc_d = branch_target;
        if (imem_rdy) state_d = FETCH;
      end
      HALTED: state_d = HALTED;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    imem_rd   = 1'b0;
    imem_addr = pc_q;
    flush     = 1'b0;
    load      = 1'b0;
    load_word = imem_data;
    halted    = 1'b0;
    case (state_q)
      FETCH: begin
        imem_rd = rst_n;
        flush   = branch_taken;
        load    = imem_rdy && !stall;
      end
      HOLD: begin
        flush     = branch_taken;
        load      = !stall;
        load_word = skid_q;
      end
      DRAIN: begin
        imem_rd   = rst_n;
        imem_addr = drain_addr_q;
        flush     = branch_taken;
      end
      HALTED: halted = 1'b1;
      default: halted = 1'b0;
    endcase
  end

  if_id_reg #(.PC_W(PC_W), .NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .hold       (stall),
    .load       (load),
    .d_instr    (load_word),
    .d_pc_plus1 (pc_q + 1'b1),
    .instr      (instr),
    .pc_plus1   (pc_plus1),
    .valid      (valid)
  );
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus randomized stall/branch/latency
// traffic checked against an address-stream model of the fetched program.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, branch_taken;
  logic [15:0] branch_target;
  logic        imem_rd, imem_rdy;
  logic [15:0] imem_addr, imem_data;
  logic [15:0] instr, pc_plus1;
  logic        valid, halted;

  if_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_rd(imem_rd), .imem_addr(imem_addr),
    .imem_rdy(imem_rdy), .imem_data(imem_data), .instr(instr),
    .pc_plus1(pc_plus1), .valid(valid), .halted(halted)
  );

  always #5 clk = ~clk;

  int          n_tests = 0, n_fail = 0;
  int          wcnt, fixed_lat;
  logic        pend;
  logic [15:0] pend_addr, exp_pc;
  logic        halted_m, hlt_gone;
  logic        prog_en;
  logic [15:0] prog [3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory image: small program override at 0..2, otherwise a hash where only
  // addresses = 22 mod 23 hold a HLT.
  function automatic logic [15:0] memword(input logic [15:0] a);
    logic [15:0] h;
    logic [3:0]  op;
    if (prog_en && a < 16'd3) return prog[a[1:0]];
    h  = a * 16'h9E37;
    h  = h ^ {a[7:0], a[15:8]} ^ 16'h5A5A;
    op = 4'(h[15:12] % 4'd15);
    if (a % 23 == 22) op = 4'hF;
    return {op, h[11:0]};
  endfunction

  function automatic int next_lat();
    return (fixed_lat < 0) ? int'($urandom_range(0, 3)) : fixed_lat;
  endfunction

  // Model: exp_pc is the address of the word decode should see next.
  task automatic model_cycle();
    logic [15:0] w;
    w = memword(exp_pc);
    if (pend) chk("addr_stable", imem_addr, pend_addr);
    if (!valid) chk("bubble_instr", instr, 16'h0000);
    if (valid && !hlt_gone) begin
      chk("instr", instr, w);
      chk("pc_plus1", pc_plus1, 16'(exp_pc + 16'd1));
      if (w[15:12] == 4'hF) halted_m = 1'b1;
    end
    if (hlt_gone) chk("post_halt_valid", valid, 1'b0);
    chk("halted", halted, halted_m);
    if (halted_m) chk("halt_rd", imem_rd, 1'b0);
    if (halted_m) begin
      if (valid && !stall) hlt_gone = 1'b1;
    end else if (branch_taken) exp_pc = branch_target;
    else if (valid && !stall) exp_pc = 16'(exp_pc + 16'd1);
  endtask

  task automatic step(input logic st, input logic br, input logic [15:0] tgt);
    logic        np;
    logic [15:0] na;
    stall = st; branch_taken = br; branch_target = tgt;
    imem_rdy  = imem_rd && (wcnt == 0);
    imem_data = imem_rdy ? memword(imem_addr) : 16'($urandom);
    np = imem_rd && !imem_rdy;
    na = imem_addr;
    model_cycle();
    if (imem_rd) wcnt = imem_rdy ? next_lat() : wcnt - 1;
    @(posedge clk);
    pend = np; pend_addr = na;
    @(negedge clk);
  endtask

  // Called at a negedge: asserts reset mid-cycle with a stray response on the bus.
  task automatic do_reset();
    #1 rst_n = 1'b0;
    stall = 1'b0; branch_taken = 1'b0; imem_rdy = 1'b1; imem_data = 16'hF000;
    #1;
    chk("rst_imem_rd", imem_rd, 1'b0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_pc_plus1", pc_plus1, 16'h0000);
    chk("rst_halted", halted, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; imem_rdy = 1'b0;
    wcnt = next_lat(); pend = 1'b0;
    exp_pc = 16'h0000; halted_m = 1'b0; hlt_gone = 1'b0;
    #1;
    chk("rst_first_rd", imem_rd, 1'b1);
    chk("rst_first_addr", imem_addr, 16'h0000);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int nv, post;
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    imem_rdy = 1'b0; imem_data = '0; fixed_lat = 0; prog_en = 1'b0;
    prog[0] = 16'h0; prog[1] = 16'h0; prog[2] = 16'h0;
    @(negedge clk);

    // Zero-wait program ending in HLT
    prog[0] = 16'h1123; prog[1] = 16'h2456; prog[2] = 16'hF000; prog_en = 1'b1;
    do_reset();
    step(0, 0, 0); chk("p0_instr", instr, 16'h1123); chk("p0_pc1", pc_plus1, 16'd1);
    step(0, 0, 0); chk("p1_instr", instr, 16'h2456); chk("p1_pc1", pc_plus1, 16'd2);
    step(0, 0, 0); chk("p2_instr", instr, 16'hF000); chk("p2_pc1", pc_plus1, 16'd3);
    chk("p2_halted", halted, 1'b1); chk("p2_rd", imem_rd, 1'b0);
    step(0, 0, 0); chk("p3_valid", valid, 1'b0); chk("p3_rd", imem_rd, 1'b0);
    step(0, 1, 16'h0020); chk("p4_halted", halted, 1'b1); chk("p4_rd", imem_rd, 1'b0);

    // 3-cycle latency: one valid cycle per word
    prog_en = 1'b0; fixed_lat = 3;
    do_reset();
    nv = 0;
    for (int i = 0; i < 13; i++) begin
      step(0, 0, 0);
      nv += int'(valid);
    end
    chk("lat3_valid_cnt", nv, 3);

    // Stall for 4 cycles while A5A5 returns
    prog[0] = 16'h1123; prog[1] = 16'hA5A5; prog[2] = 16'h2456; prog_en = 1'b1; fixed_lat = 0;
    do_reset();
    step(0, 0, 0); chk("st_first", instr, 16'h1123);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0); chk("st_hold", instr, 16'h1123);
    end
    step(0, 0, 0); chk("st_a5a5", instr, 16'hA5A5); chk("st_pc1", pc_plus1, 16'd2);
    step(0, 0, 0); chk("st_next", instr, 16'h2456); chk("st_next_pc1", pc_plus1, 16'd3);

    // Branch to 0040 during a 3-cycle read of address 5
    prog_en = 1'b0; fixed_lat = 0;
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    fixed_lat = 3;
    step(0, 0, 0);
    step(0, 0, 0); chk("br_pre_addr", imem_addr, 16'd5);
    step(0, 1, 16'h0040);
    chk("br_flush", valid, 1'b0); chk("br_drain_addr", imem_addr, 16'd5); chk("br_drain_rd", imem_rd, 1'b1);
    step(0, 0, 0); chk("br_drain_addr2", imem_addr, 16'd5);
    step(0, 0, 0); chk("br_new_addr", imem_addr, 16'h0040); chk("br_discard", valid, 1'b0);

    // HLT response coincident with a branch
    prog[0] = 16'hF000; prog_en = 1'b1; fixed_lat = 0;
    do_reset();
    step(0, 1, 16'h0010);
    chk("hb_halted", halted, 1'b0); chk("hb_addr", imem_addr, 16'h0010); chk("hb_valid", valid, 1'b0);
    step(0, 0, 0);
    chk("hb_valid2", valid, 1'b1); chk("hb_pc1", pc_plus1, 16'h0011); chk("hb_instr", instr, memword(16'h0010));

    // PC wrap at FFFF
    prog_en = 1'b0;
    do_reset();
    step(0, 1, 16'hFFFF);
    step(0, 0, 0);
    chk("wrap_pc1", pc_plus1, 16'h0000); chk("wrap_addr", imem_addr, 16'h0000);
    chk("wrap_instr", instr, memword(16'hFFFF));

    // Reset mid-request with PC at FFFF
    fixed_lat = 3;
    do_reset();
    step(0, 1, 16'hFFFF);
    step(0, 0, 0);
    do_reset();
    step(0, 0, 0); chk("rst_mid_valid", valid, 1'b0);

    // Randomized traffic
    fixed_lat = -1;
    for (int ep = 0; ep < 30; ep++) begin
      do_reset();
      post = 0;
      for (int c = 0; c < 200 && post < 4; c++) begin
        logic st, br;
        logic [15:0] tg;
        st = ($urandom_range(0, 9) < 3);
        br = ($urandom_range(0, 19) == 0);
        tg = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFE + 16'($urandom_range(0, 1))) : 16'($urandom);
        if ($urandom_range(0, 149) == 0) do_reset();
        else step(st, br, tg);
        if (hlt_gone) post++;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
